ft_recovery_ctrl: RTL and testbench
===================================

# ft_recovery_ctrl

Recovery controller that sits directly downstream of `ft_system` and consumes its mismatch report (`addr_o`, `data_o`, `fetch_block_o`). When the duplicated write lanes disagree, it stalls fetch and writes the reported golden data back to both register-file copies. It then re-checks the mismatch flag and retries a bounded number of times. If the mismatch persists, it declares a sticky fatal error. It also keeps a saturating count of recovery events for status readout.

## Interface

- `ADDR_WIDTH`, default 5: register-file address width.
- `DATA_WIDTH`, default 32 (`2**ADDR_WIDTH`): data width.
- `MAX_RETRY`, default 3: correction attempts allowed after the first write. Legal range is 1..7.
- `CNT_WIDTH`, default 8: width of the event counter.

- `clk_i` — in, 1: single clock; all logic is rising-edge.
- `rst_ni` — in, 1: reset is synchronous and active-low.
- `fetch_block_i` — in, 1: mismatch flag; connects to `ft_system.fetch_block_o`.
- `err_addr_i` — in, ADDR_WIDTH: mismatching address; connects to `ft_system.addr_o`.
- `err_data_i` — in, DATA_WIDTH: golden data; connects to `ft_system.data_o`.
- `stall_o` — out, 1: holds core fetch while recovery is in progress.
- `fix_we_o` — out, 1: correction write enable, applied to both lanes (`we_a_i` and `we_b_i`).
- `fix_addr_o` — out, ADDR_WIDTH: correction address.
- `fix_data_o` — out, DATA_WIDTH: correction data.
- `done_o` — out, 1: one-cycle pulse marking a successful recovery.
- `fatal_o` — out, 1: sticky; retries are exhausted.
- `err_count_o` — out, CNT_WIDTH: number of recovery events, saturating.

## Operation

- **Registered outputs.** All outputs come straight from flops. FSM states are IDLE, WRITE, SETTLE, CHECK and FATAL.
- **IDLE.**
  - `fetch_block_i` is sampled every cycle.
  - When it is 1: latch `err_addr_i`/`err_data_i` into `fix_addr_o`/`fix_data_o`, clear the retry counter, increment `err_count_o` (saturating), and go to WRITE.
- **WRITE.** `fix_we_o`=1 for exactly this one cycle. Next state is SETTLE.
- **SETTLE.** `fix_we_o`=0. This cycle lets `ft_system` re-compare. Next state is CHECK.
- **CHECK.** `fetch_block_i` is sampled:
  - If 0: go to IDLE and assert `done_o` in that IDLE cycle.
  - If 1 and retry count < MAX_RETRY: increment the retry count, re-latch `err_addr_i`/`err_data_i` (the address may differ from the previous attempt), and go to WRITE.
  - If 1 and retry count == MAX_RETRY: go to FATAL.
- **FATAL.**
  - `fatal_o`=1 and `stall_o`=1.
  - `fix_we_o`=0.
  - `fetch_block_i` is ignored.
  - The only exit is `rst_ni`=0.
- **`stall_o`.** High in WRITE, SETTLE, CHECK and FATAL; low in IDLE.
- **`done_o` cycle.** The `done_o` cycle is an ordinary IDLE cycle:
  - a new `fetch_block_i`=1 seen in it starts a new event;
  - that new event increments `err_count_o` again.
- **Counters.**
  - The retry counter is 3 bits and is cleared on every entry from IDLE.
  - `err_count_o` counts events, not retries, and holds at all-ones once reached.

## Timing

- **Reset values.** These are all 0, and `err_count_o` is also cleared:
  - `stall_o`, `fix_we_o`, `fix_addr_o`, `fix_data_o`
  - `done_o`, `fatal_o`
  - the FSM returns to IDLE
- **Reset in any state.** `rst_ni` low at an edge forces the reset values at that edge, including mid-WRITE and in FATAL.
- **Event at edge E0** (`fetch_block_i` sampled 1 in IDLE):
  - cycle E0+1: WRITE; `fix_we_o`=1, `stall_o`=1
  - cycle E0+2: SETTLE
  - cycle E0+3: CHECK
  - cycle E0+4: IDLE with `done_o`=1 and `stall_o`=0, if the mismatch has cleared
- **Clean recovery.** Best-case recovery takes 4 cycles. `stall_o` is high for exactly 3 cycles.
- **Retry.** Each retry adds 3 cycles (WRITE, SETTLE, CHECK).
- **Worst case.** Total writes are 1+MAX_RETRY. FATAL is entered on the cycle after the last CHECK.
- **Correction data.** `fix_addr_o`/`fix_data_o` are stable from WRITE through CHECK. They update only when re-latched.

## Test plan

- **Reset:** drive `rst_ni`=0 for 2 cycles with `fetch_block_i`=1 → all outputs stay 0 and there is no WRITE.
- **Single event:** in IDLE, drive `fetch_block_i`=1 with `err_addr_i`=10, `err_data_i`=100; deassert before CHECK.
  - `fix_we_o`=1 for one cycle at E0+1, with addr 10 and data 100.
  - `stall_o` is high at E0+1..E0+3.
  - `done_o` pulses at E0+4.
  - `err_count_o`=1.
- **Retry then success:** `fetch_block_i` is high at the first CHECK and low at the second, with the address changed to 7 before the first CHECK.
  - Exactly 2 writes: addr 10, then addr 7.
  - `done_o` at E0+7.
  - `err_count_o`=1.
- **Persistent mismatch:** hold `fetch_block_i`=1 with MAX_RETRY=3.
  - Exactly 4 write pulses.
  - `fatal_o`=1 from E0+13.
  - `stall_o` stays 1 after `fetch_block_i` drops; only reset clears it.
- **Saturation:** with CNT_WIDTH=2, run 5 successful events back-to-back, each starting in the `done_o` cycle of the previous one.
  - `err_count_o` reads 1, 2, 3, 3, 3.
- **Reset mid-operation:** assert `rst_ni`=0 during WRITE → the next cycle shows `fix_we_o`=0, `stall_o`=0, `err_count_o`=0 and the FSM in IDLE.

Source files
------------

// File: rtl/ft_recovery_if.sv
// Bundle between ft_system's mismatch report and the recovery controller:
// mismatch flag, address and golden data in; correction write and status out.
interface ft_recovery_if #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 8
);
  logic                  fetch_block;
  logic [ADDR_WIDTH-1:0] err_addr;
  logic [DATA_WIDTH-1:0] err_data;
  logic                  stall;
  logic                  fix_we;
  logic [ADDR_WIDTH-1:0] fix_addr;
  logic [DATA_WIDTH-1:0] fix_data;
  logic                  done;
  logic                  fatal;
  logic [CNT_WIDTH-1:0]  err_count;

  modport master (
    output fetch_block, err_addr, err_data,
    input  stall, fix_we, fix_addr, fix_data, done, fatal, err_count
  );

  modport slave (
    input  fetch_block, err_addr, err_data,
    output stall, fix_we, fix_addr, fix_data, done, fatal, err_count
  );
endinterface

// File: rtl/ft_recovery_ctrl.sv
// Recovery controller: on a lane mismatch, stall fetch, rewrite golden data to
// both register-file copies, re-check, retry a bounded number of times, else go fatal.
module ft_recovery_ctrl #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 2**ADDR_WIDTH,
  parameter int MAX_RETRY  = 3,
  parameter int CNT_WIDTH  = 8
) (
  input logic          clk_i,
  input logic          rst_ni,
  ft_recovery_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WRITE  = 3'd1,
    SETTLE = 3'd2,
    CHECK  = 3'd3,
    FATAL  = 3'd4
  } state_e;

  state_e                state_r;
  logic [2:0]            retry_r;
  logic                  stall_r;
  logic                  fix_we_r;
  logic [ADDR_WIDTH-1:0] fix_addr_r;
  logic [DATA_WIDTH-1:0] fix_data_r;
  logic                  done_r;
  logic                  fatal_r;
  logic [CNT_WIDTH-1:0]  err_count_r;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] value);
    if (value == {CNT_WIDTH{1'b1}}) begin
      sat_inc = value;
    end else begin
      sat_inc = value + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end
  endfunction

  // Recovery FSM; every output is a flop updated alongside the state
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_r     <= IDLE;
      retry_r     <= 3'd0;
      stall_r     <= 1'b0;
      fix_we_r    <= 1'b0;
      fix_addr_r  <= {ADDR_WIDTH{1'b0}};
      fix_data_r  <= {DATA_WIDTH{1'b0}};
      done_r      <= 1'b0;
      fatal_r     <= 1'b0;
      err_count_r <= {CNT_WIDTH{1'b0}};
    end else begin
      done_r   <= 1'b0;
      fix_we_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (bus.fetch_block) begin
            state_r     <= WRITE;
            retry_r     <= 3'd0;
            stall_r     <= 1'b1;
            fix_we_r    <= 1'b1;
            fix_addr_r  <= bus.err_addr;
            fix_data_r  <= bus.err_data;
            err_count_r <= sat_inc(err_count_r);
          end else begin
            stall_r <= 1'b0;
          end
        end
        WRITE:  state_r <= SETTLE;
        SETTLE: state_r <= CHECK;
        CHECK: begin
          if (!bus.fetch_block) begin
            state_r <= IDLE;
            stall_r <= 1'b0;
            done_r  <= 1'b1;
          end else if (retry_r < 3'(MAX_RETRY)) begin
            // the failing address may have moved since the last attempt
            state_r    <= WRITE;
            retry_r    <= retry_r + 3'd1;
            fix_we_r   <= 1'b1;
            fix_addr_r <= bus.err_addr;
            fix_data_r <= bus.err_data;
          end else begin
            state_r <= FATAL;
            fatal_r <= 1'b1;
          end
        end
        FATAL: begin
          state_r <= FATAL;
          stall_r <= 1'b1;
          fatal_r <= 1'b1;
        end
        default: begin
          state_r <= IDLE;
          stall_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.stall     = stall_r;
  assign bus.fix_we    = fix_we_r;
  assign bus.fix_addr  = fix_addr_r;
  assign bus.fix_data  = fix_data_r;
  assign bus.done      = done_r;
  assign bus.fatal     = fatal_r;
  assign bus.err_count = err_count_r;

endmodule

// File: tb/tb_ft_recovery_ctrl.sv
// Directed bench for ft_recovery_ctrl; expected correction writes are queued
// when a mismatch is driven and popped as the DUT issues each write.
module tb_ft_recovery_ctrl;
  localparam int AW = 5;
  localparam int DW = 32;
  localparam int CW = 2;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad = 0;
  int   wr_cnt = 0;
  logic [AW+DW-1:0] exp_q[$];

  ft_recovery_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) bus ();

  ft_recovery_ctrl #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_RETRY(3), .CNT_WIDTH(CW)
  ) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic fb, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.fetch_block = fb;
    bus.err_addr    = a;
    bus.err_data    = d;
  endtask

  // Scoreboard: every write pulse must match the oldest queued expectation
  always @(negedge clk) begin
    if (bus.fix_we === 1'b1) begin
      wr_cnt++;
      if (exp_q.size() == 0) begin
        chk("sb_unexpected_write", 64'(bus.fix_we), 64'd0);
      end else begin
        chk("sb_write", 64'({bus.fix_addr, bus.fix_data}), 64'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held two cycles with a mismatch present
    rst_n = 1'b0;
    drive(1'b1, 5'd3, 32'd33);
    step();
    step();
    chk("rst_stall", 64'(bus.stall), 64'd0);
    chk("rst_we", 64'(bus.fix_we), 64'd0);
    chk("rst_addr", 64'(bus.fix_addr), 64'd0);
    chk("rst_data", 64'(bus.fix_data), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_fatal", 64'(bus.fatal), 64'd0);
    chk("rst_count", 64'(bus.err_count), 64'd0);
    chk("rst_no_write", 64'(wr_cnt), 64'd0);
    drive(1'b0, 5'd0, 32'd0);
    rst_n = 1'b1;
    step();

    // Single clean event
    wr_cnt = 0;
    drive(1'b1, 5'd10, 32'd100);
    exp_q.push_back({5'd10, 32'd100});
    step();
    chk("single_we_e1", 64'(bus.fix_we), 64'd1);
    chk("single_stall_e1", 64'(bus.stall), 64'd1);
    chk("single_count", 64'(bus.err_count), 64'd1);
    drive(1'b0, 5'd10, 32'd100);
    step();
    chk("single_we_e2", 64'(bus.fix_we), 64'd0);
    chk("single_stall_e2", 64'(bus.stall), 64'd1);
    chk("single_addr_e2", 64'(bus.fix_addr), 64'd10);
    step();
    chk("single_stall_e3", 64'(bus.stall), 64'd1);
    chk("single_done_e3", 64'(bus.done), 64'd0);
    step();
    chk("single_done_e4", 64'(bus.done), 64'd1);
    chk("single_stall_e4", 64'(bus.stall), 64'd0);
    step();
    chk("single_done_e5", 64'(bus.done), 64'd0);
    chk("single_writes", 64'(wr_cnt), 64'd1);

    // Retry then success, address moves before first CHECK
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    wr_cnt = 0;
    drive(1'b1, 5'd10, 32'd100);
    exp_q.push_back({5'd10, 32'd100});
    step();
    drive(1'b1, 5'd7, 32'd77);
    exp_q.push_back({5'd7, 32'd77});
    step();
    step();
    chk("retry_done_e3", 64'(bus.done), 64'd0);
    step();
    chk("retry_we_e4", 64'(bus.fix_we), 64'd1);
    chk("retry_addr_e4", 64'(bus.fix_addr), 64'd7);
    drive(1'b0, 5'd7, 32'd77);
    step();
    step();
    chk("retry_done_e6", 64'(bus.done), 64'd0);
    step();
    chk("retry_done_e7", 64'(bus.done), 64'd1);
    chk("retry_count", 64'(bus.err_count), 64'd1);
    chk("retry_writes", 64'(wr_cnt), 64'd2);

    // Persistent mismatch runs out of retries
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    wr_cnt = 0;
    drive(1'b1, 5'd5, 32'd55);
    for (int i = 0; i < 4; i++) exp_q.push_back({5'd5, 32'd55});
    for (int i = 0; i < 12; i++) step();
    chk("persist_fatal_e12", 64'(bus.fatal), 64'd0);
    step();
    chk("persist_fatal_e13", 64'(bus.fatal), 64'd1);
    chk("persist_stall_e13", 64'(bus.stall), 64'd1);
    drive(1'b0, 5'd0, 32'd0);
    for (int i = 0; i < 5; i++) step();
    chk("persist_stall_hold", 64'(bus.stall), 64'd1);
    chk("persist_fatal_hold", 64'(bus.fatal), 64'd1);
    chk("persist_we_hold", 64'(bus.fix_we), 64'd0);
    chk("persist_writes", 64'(wr_cnt), 64'd4);
    rst_n = 1'b0;
    step();
    chk("persist_rst_fatal", 64'(bus.fatal), 64'd0);
    chk("persist_rst_stall", 64'(bus.stall), 64'd0);
    rst_n = 1'b1;
    step();

    // Back-to-back events saturate the 2-bit counter
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, 5'(k + 1), 32'(k + 200));
      exp_q.push_back({5'(k + 1), 32'(k + 200)});
      step();
      chk("sat_count", 64'(bus.err_count), (k < 3) ? 64'(k + 1) : 64'd3);
      drive(1'b0, 5'd0, 32'd0);
      step();
      step();
      step();
      chk("sat_done", 64'(bus.done), 64'd1);
    end
    step();

    // Reset during WRITE
    drive(1'b1, 5'd9, 32'd99);
    exp_q.push_back({5'd9, 32'd99});
    step();
    chk("mid_we_before", 64'(bus.fix_we), 64'd1);
    rst_n = 1'b0;
    drive(1'b0, 5'd0, 32'd0);
    step();
    chk("mid_we", 64'(bus.fix_we), 64'd0);
    chk("mid_stall", 64'(bus.stall), 64'd0);
    chk("mid_count", 64'(bus.err_count), 64'd0);
    rst_n = 1'b1;
    step();
    drive(1'b1, 5'd4, 32'd44);
    exp_q.push_back({5'd4, 32'd44});
    step();
    chk("mid_idle_restart_we", 64'(bus.fix_we), 64'd1);
    chk("mid_idle_restart_count", 64'(bus.err_count), 64'd1);
    drive(1'b0, 5'd0, 32'd0);
    for (int i = 0; i < 4; i++) step();

    chk("sb_empty", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
